// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply / restoring divide for the EX stage.
// Produces a one-cycle dual-register write (result_lo to dest, result_hi to HI_REG).
module muldiv_unit #(
  parameter logic [3:0] HI_REG = 4'd15,
  parameter int         ITER   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [3:0]  dest_reg,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  output logic        stall,
  output logic        busy,
  output logic        reg_write,
  output logic        write_op2,
  output logic [3:0]  write_reg1,
  output logic [3:0]  write_reg2,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi,
  output logic        div_by_zero
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic          op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic          reg_write_q, reg_write_d, write_op2_q, write_op2_d, dbz_q, dbz_d;
  logic [3:0]    wr1_q, wr1_d, wr2_q, wr2_d;
  logic [15:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;

  // acc_lo holds the multiplier (mul) or dividend/quotient (div); opnd is the other operand
  logic [16:0] mul_sum, rem_s, trial;
  logic [15:0] mul_hi, mul_lo, div_rem, div_quot;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 17'd0);
    mul_hi   = mul_sum[16:1];
    mul_lo   = {mul_sum[0], acc_lo_q[15:1]};
    rem_s    = {acc_hi_q, acc_lo_q[15]};
    trial    = rem_s - {1'b0, opnd_q};
    div_rem  = trial[16] ? rem_s[15:0] : trial[15:0];
    div_quot = {acc_lo_q[14:0], ~trial[16]};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    reg_write_d = 1'b0;
    write_op2_d = 1'b0;
    dbz_d       = 1'b0;
    wr1_d       = wr1_q;
    wr2_d       = HI_REG;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    case (state_q)
      IDLE: if (start) begin
        op_d     = op;
        wr1_d    = dest_reg;
        acc_hi_d = 16'd0;
        acc_lo_d = op ? operand_a : operand_b;
        opnd_d   = op ? operand_b : operand_a;
        cnt_d    = CW'(ITER - 1);
        if (op && operand_b == 16'd0) begin
          state_d     = DONE;
          reg_write_d = 1'b1;
          write_op2_d = 1'b1;
          dbz_d       = 1'b1;
          res_lo_d    = 16'hFFFF;
          res_hi_d    = operand_a;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        acc_hi_d = op_q ? div_rem  : mul_hi;
        acc_lo_d = op_q ? div_quot : mul_lo;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          reg_write_d = 1'b1;
          write_op2_d = 1'b1;
          res_lo_d    = acc_lo_d;
          res_hi_d    = acc_hi_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      reg_write_q <= 1'b0;
      write_op2_q <= 1'b0;
      dbz_q       <= 1'b0;
      wr1_q       <= 4'd0;
      wr2_q       <= HI_REG;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      reg_write_q <= reg_write_d;
      write_op2_q <= write_op2_d;
      dbz_q       <= dbz_d;
      wr1_q       <= wr1_d;
      wr2_q       <= wr2_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
    end
  end

  // stall drops in DONE so the instruction retires with its write
  assign stall       = (state_q == IDLE && start) || state_q == RUN;
  assign busy        = state_q != IDLE;
  assign reg_write   = reg_write_q;
  assign write_op2   = write_op2_q;
  assign write_reg1  = wr1_q;
  assign write_reg2  = wr2_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, op = 1'b0;
  logic [3:0]  dest_reg = 4'd0;
  logic [15:0] operand_a = 16'd0, operand_b = 16'd0;
  logic        stall, busy, reg_write, write_op2, div_by_zero;
  logic [3:0]  write_reg1, write_reg2;
  logic [15:0] result_lo, result_hi;

  int checks = 0, errors = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dest_reg(dest_reg),
    .operand_a(operand_a), .operand_b(operand_b), .stall(stall), .busy(busy),
    .reg_write(reg_write), .write_op2(write_op2), .write_reg1(write_reg1),
    .write_reg2(write_reg2), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_outs"}, {stall, busy, reg_write, write_op2, div_by_zero, write_reg1, write_reg2},
        {5'b00000, 4'd0, 4'd15});
    chk({tag, "_res"}, {result_hi, result_lo}, 32'd0);
  endtask

  // Issue one operation and check the write against plain arithmetic.
  // poke: re-assert start with different operands 5 cycles into RUN.
  task automatic run_op(input string tag, input logic o, input logic [3:0] d,
                        input logic [15:0] a, input logic [15:0] b, input bit poke);
    logic [31:0] prod;
    logic [15:0] exp_lo, exp_hi;
    bit dz;
    int lat, stall_cnt;
    dz   = o && b == 16'd0;
    prod = a * b;
    if (!o)     begin exp_lo = prod[15:0]; exp_hi = prod[31:16]; end
    else if (dz) begin exp_lo = 16'hFFFF;  exp_hi = a;           end
    else        begin exp_lo = a / b;      exp_hi = a % b;       end

    @(negedge clk);
    start = 1'b1; op = o; dest_reg = d; operand_a = a; operand_b = b;
    #1;
    stall_cnt = stall ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; operand_a = ~a; operand_b = ~b; dest_reg = ~d;
    lat = 0;
    while (!reg_write && lat < 40) begin
      if (stall) stall_cnt++;
      if (poke && lat == 5) begin
        start = 1'b1; op = ~o; dest_reg = d + 4'd1;
        operand_a = 16'h5A5A; operand_b = 16'h0003;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, dz ? 0 : 16);
    chk({tag, "_stallcyc"}, stall_cnt, dz ? 1 : 17);
    chk({tag, "_done"}, {reg_write, write_op2, stall, busy, div_by_zero}, {4'b1101, dz});
    chk({tag, "_wregs"}, {write_reg1, write_reg2}, {d, 4'd15});
    chk({tag, "_res"}, {result_hi, result_lo}, {exp_hi, exp_lo});
    @(posedge clk); #1;
    chk({tag, "_after"}, {reg_write, write_op2, busy, div_by_zero}, 4'b0000);
  endtask

  initial begin
    bit o;
    logic [15:0] a, b;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post_release");

    run_op("mul_1234x10", 1'b0, 4'd3, 16'h1234, 16'h0010, 1'b0);
    run_op("mul_ffffxffff", 1'b0, 4'd4, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("div_f_2", 1'b1, 4'd2, 16'h000F, 16'h0002, 1'b0);
    run_op("div_by_zero", 1'b1, 4'd7, 16'h1234, 16'h0000, 1'b0);
    run_op("mul_poked", 1'b0, 4'd9, 16'h0ABC, 16'h0123, 1'b1);
    run_op("div_dest_hi", 1'b1, 4'd15, 16'hFFFF, 16'h0001, 1'b0);
    run_op("div_big_divisor", 1'b1, 4'd1, 16'h8000, 16'hFFFF, 1'b0);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 1'b1; dest_reg = 4'd5; operand_a = 16'hBEEF; operand_b = 16'h0013;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (reg_write || busy) seen = 1'b1;
    end
    chk("midrst_no_stale_write", seen, 1'b0);
    run_op("after_rst", 1'b1, 4'd6, 16'hBEEF, 16'h0013, 1'b0);

    for (int i = 0; i < 30; i++) begin
      o = $urandom_range(1);
      a = 16'($urandom);
      b = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
      run_op($sformatf("rnd%0d", i), o, 4'($urandom), a, b, $urandom_range(3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
